prng_vec_dispenser: RTL

//  Consumer end of the free-running random unit-vector stream (one fp24_vec3 per clk, no handshake).

---
 rtl/prng_vec_dispenser_pkg.sv | 25 ++
 rtl/prng_vec_dispenser_fifo.sv | 52 +++++
 rtl/prng_vec_dispenser.sv | 92 +++++++++
 3 files changed

// File: rtl/prng_vec_dispenser_pkg.sv
// Shared fp24 vector types and helpers for the random unit-vector path.
// fp24 layout: sign [23], exponent [22:16] (bias 63), mantissa [15:0].
package prng_vec_dispenser_pkg;

    typedef logic [23:0] fp24;

    typedef struct packed {
        fp24 x;
        fp24 y;
        fp24 z;
    } fp24_vec3;

    localparam int FP24_SIGN_BIT = 23;

    // Sign flip only: magnitude bits pass through untouched.
    function automatic fp24_vec3 fp24_vec3_negate(input fp24_vec3 v);
        fp24_vec3 r;
        r = v;
        r.x[FP24_SIGN_BIT] = ~v.x[FP24_SIGN_BIT];
        r.y[FP24_SIGN_BIT] = ~v.y[FP24_SIGN_BIT];
        r.z[FP24_SIGN_BIT] = ~v.z[FP24_SIGN_BIT];
        return r;
    endfunction

endpackage

// File: rtl/prng_vec_dispenser_fifo.sv
// Synchronous FIFO of fp24_vec3 samples; head is presented combinationally.
module rng_vec_fifo
    import prng_vec_dispenser_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fp24_vec3                 wr_data,
    input  logic                     pop,
    output fp24_vec3                 rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fp24_vec3           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prng_vec_dispenser.sv
// Banks the free-running random unit-vector stream after warm-up and serves
// one vector per tagged request, optionally negated into the caller's hemisphere.
module prng_vec_dispenser
    import prng_vec_dispenser_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WARMUP = 16,
    parameter int ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  fp24_vec3                 rng_vec,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ID_W-1:0]          req_id,
    input  logic                     req_neg,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output fp24_vec3                 resp_vec,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              drop_count
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WARM_W = $clog2(WARMUP + 1);

    logic [WARM_W-1:0] warm_cnt;
    logic              warm;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic [CNT_W-1:0]  count;
    fp24_vec3          head;

    // Handshakes: a transfer happens on a clock edge where valid & ready are both
    // high; valid never waits on ready, and an offered response holds its payload
    // stable until it is taken.
    assign warm      = (warm_cnt == WARM_W'(WARMUP));
    assign full      = (count == CNT_W'(DEPTH));
    assign req_ready = warm && (count != '0) && (!resp_valid || resp_ready);
    assign pop       = req_valid && req_ready;
    assign push      = warm && (!full || pop);
    assign drop      = warm && full && !pop;

    assign fill_level = count;

    rng_vec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (rng_vec),
        .pop     (pop),
        .rd_data (head),
        .count   (count)
    );

    // Samples before warm-up come from a pipeline that has not filled yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if (!warm) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_vec   <= '0;
        end else if (pop) begin
            resp_valid <= 1'b1;
            resp_id    <= req_id;
            resp_vec   <= req_neg ? fp24_vec3_negate(head) : head;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule
